// File: rtl/md5_block_sched.sv
// Block sequencer for an MD5 compression core: takes padded 512-bit blocks, drives the core,
// keeps the chaining value across blocks, adds the core output into it and presents the digest.
module md5_block_sched #(
   parameter logic [127:0] IV          = 128'h67452301_efcdab89_98badcfe_10325476,
   parameter int           TIMEOUT_CYC = 256
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         blk_valid_i,
   output logic         blk_ready_o,
   input  logic         blk_first_i,
   input  logic         blk_last_i,
   input  logic [511:0] blk_data_i,
   output logic         core_start_o,
   output logic [511:0] core_msg_o,
   output logic [127:0] core_iv_o,
   input  logic         core_done_i,
   input  logic [127:0] core_state_i,
   output logic         digest_valid_o,
   input  logic         digest_ready_i,
   output logic [127:0] digest_o,
   output logic         busy_o,
   output logic         err_o
);

   localparam int             TMR_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_OUT
   } state_t;

   state_t           r_state;
   logic [127:0]     r_cv;
   logic             r_chain_ok;
   logic [TMR_W-1:0] r_timer;
   logic             r_last;

   logic             r_blk_ready;
   logic             r_core_start;
   logic [511:0]     r_core_msg;
   logic [127:0]     r_core_iv;
   logic             r_digest_valid;
   logic [127:0]     r_digest;
   logic             r_busy;
   logic             r_err;

   logic             w_accept;
   logic [TMR_W-1:0] w_timer_nxt;
   logic             w_timeout;
   logic [127:0]     w_cv_sum;

   assign w_accept    = (r_state == S_IDLE) && blk_valid_i && r_blk_ready;
   assign w_timer_nxt = r_timer + TMR_W'(1);
   assign w_timeout   = (w_timer_nxt == TMR_LAST);

   // Per-word CV addition; each 32-bit lane wraps independently.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_cv_sum = '0;
      for (int w = 0; w < 4; w++) begin
         w_cv_sum[32*w +: 32] = r_cv[32*w +: 32] + core_state_i[32*w +: 32];
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every read in this block sees
   // the value from before the edge regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state        <= S_IDLE;
         r_cv           <= IV;
         r_chain_ok     <= 1'b0;
         r_timer        <= '0;
         r_last         <= 1'b0;
         r_blk_ready    <= 1'b0;
         r_core_start   <= 1'b0;
         r_core_msg     <= '0;
         r_core_iv      <= '0;
         r_digest_valid <= 1'b0;
         r_digest       <= '0;
         r_busy         <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_core_start <= 1'b0;
         r_err        <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_blk_ready <= 1'b1;
               if (w_accept) begin
                  r_core_msg <= blk_data_i;
                  r_last     <= blk_last_i;
                  if (blk_first_i) begin
                     r_cv         <= IV;
                     r_chain_ok   <= 1'b1;
                     r_core_iv    <= IV;
                     r_core_start <= 1'b1;
                     r_blk_ready  <= 1'b0;
                     r_busy       <= 1'b1;
                     r_state      <= S_START;
                  end else if (!r_chain_ok) begin
                     // Continuation block with no message in progress: drop it.
                     r_err <= 1'b1;
                  end else begin
                     r_core_iv    <= r_cv;
                     r_core_start <= 1'b1;
                     r_blk_ready  <= 1'b0;
                     r_busy       <= 1'b1;
                     r_state      <= S_START;
                  end
               end
            end

            S_START: begin
               r_timer <= '0;
               r_state <= S_RUN;
            end

            S_RUN: begin
               r_timer <= w_timer_nxt;
               if (core_done_i) begin
                  r_cv <= w_cv_sum;
                  if (r_last) begin
                     r_digest       <= w_cv_sum;
                     r_digest_valid <= 1'b1;
                     r_state        <= S_OUT;
                  end else begin
                     r_blk_ready <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= S_IDLE;
                  end
               end else if (w_timeout) begin
                  r_err       <= 1'b1;
                  r_chain_ok  <= 1'b0;
                  r_blk_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            S_OUT: begin
               if (digest_ready_i) begin
                  r_digest_valid <= 1'b0;
                  r_chain_ok     <= 1'b0;
                  r_blk_ready    <= 1'b1;
                  r_busy         <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign blk_ready_o    = r_blk_ready;
   assign core_start_o   = r_core_start;
   assign core_msg_o     = r_core_msg;
   assign core_iv_o      = r_core_iv;
   assign digest_valid_o = r_digest_valid;
   assign digest_o       = r_digest;
   assign busy_o         = r_busy;
   assign err_o          = r_err;

endmodule
